// File: rtl/core_pkg.sv
// core_pkg: shared core types (pc_mux branch select, fetch FSM states, instruction size)
package core_pkg;
  typedef enum logic {NEXTPC = 1'b0, OFFSET = 1'b1} pc_mux;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, EXEC, HALT} fetch_state_e;
  localparam logic [31:0] INSTR_BYTES = 32'd4;
endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: one-outstanding fetch FSM; mem req/addr/gnt/rvalid/rdata, pc/pc4/instr to decode, pc_mux/offset/retire in, fetch_error/retired_count out
module instr_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        instr_mem_req_op,
  output logic [31:0] instr_mem_addr_op,
  input  logic        instr_mem_gnt_ip,
  input  logic        instr_mem_rvalid_ip,
  input  logic [31:0] instr_mem_rdata_ip,
  output logic [31:0] pc_op,
  output logic [31:0] pc4_op,
  output logic [31:0] instr_data_op,
  output logic        instr_data_valid_op,
  input  pc_mux       pc_mux_ip,
  input  logic [31:0] pc_branch_offset_ip,
  input  logic        retire_ip,
  output logic        fetch_error_op,
  output logic [31:0] retired_count_op
);
  fetch_state_e state, state_d;
  logic [31:0] next_pc;
  logic retire, misaligned;
  assign pc4_op = pc_op + INSTR_BYTES;
  assign next_pc = pc_mux_ip == OFFSET ? pc_op + pc_branch_offset_ip : pc4_op;
  assign misaligned = |next_pc[1:0];
  assign retire = state == EXEC && retire_ip;
  assign instr_mem_req_op = state == REQ;
  assign instr_mem_addr_op = pc_op;
  assign instr_data_valid_op = state == EXEC;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = REQ;
      REQ:     state_d = instr_mem_gnt_ip ? WAIT : REQ;
      WAIT:    state_d = instr_mem_rvalid_ip ? EXEC : WAIT;
      EXEC:    state_d = retire_ip ? (misaligned ? HALT : REQ) : EXEC;
      default: state_d = state;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc_op <= RESET_PC;
      instr_data_op <= '0;
      fetch_error_op <= 1'b0;
      retired_count_op <= '0;
    end else begin
      state <= state_d;
      if (state == WAIT && instr_mem_rvalid_ip) instr_data_op <= instr_mem_rdata_ip;
      if (retire) begin
        retired_count_op <= retired_count_op + 32'd1;
        if (misaligned) fetch_error_op <= 1'b1;
        else pc_op <= next_pc;
      end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized self-checking bench for instr_fetch against a transaction-level PC/retire model
module tb_instr_fetch;
  import core_pkg::*;
  localparam logic [31:0] RP = 32'h0000_0000;
  logic clk = 0, rst_n = 1;
  logic instr_mem_req_op, instr_mem_gnt_ip = 0, instr_mem_rvalid_ip = 0;
  logic [31:0] instr_mem_addr_op, instr_mem_rdata_ip = 0;
  logic [31:0] pc_op, pc4_op, instr_data_op, retired_count_op;
  logic instr_data_valid_op, fetch_error_op, retire_ip = 0;
  pc_mux pc_mux_ip = NEXTPC;
  logic [31:0] pc_branch_offset_ip = 0;
  int checks = 0, failures = 0;
  logic [31:0] exp_pc, exp_cnt;
  bit halted;
  always #5 clk = ~clk;
  instr_fetch #(.RESET_PC(RP)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_mem_req_op(instr_mem_req_op), .instr_mem_addr_op(instr_mem_addr_op),
    .instr_mem_gnt_ip(instr_mem_gnt_ip), .instr_mem_rvalid_ip(instr_mem_rvalid_ip),
    .instr_mem_rdata_ip(instr_mem_rdata_ip), .pc_op(pc_op), .pc4_op(pc4_op),
    .instr_data_op(instr_data_op), .instr_data_valid_op(instr_data_valid_op),
    .pc_mux_ip(pc_mux_ip), .pc_branch_offset_ip(pc_branch_offset_ip), .retire_ip(retire_ip),
    .fetch_error_op(fetch_error_op), .retired_count_op(retired_count_op)
  );

  function automatic void model_reset();
    exp_pc = RP;
    exp_cnt = 0;
    halted = 0;
  endfunction

  function automatic void model_retire(pc_mux m, logic [31:0] off);
    logic [31:0] t = exp_pc + (m == OFFSET ? off : 32'd4);
    exp_cnt = exp_cnt + 1;
    if (t % 4 != 0) halted = 1;
    else exp_pc = t;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0;
    instr_mem_gnt_ip = 0;
    instr_mem_rvalid_ip = 0;
    retire_ip = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  // Drives one fetch: gnt after gd stall cycles, rvalid after rd wait cycles. Returns the
  // request address, how many REQ cycles showed a stable request, and how many cycles
  // showed valid (or a request during WAIT) before the instruction should be held.
  task automatic fetch(input int gd, input int rd, input logic [31:0] data, input bit noise,
                       output logic [31:0] addr, output int held, output int bad);
    int n = 0;
    held = 0;
    bad = 0;
    while (!instr_mem_req_op && n < 10) begin
      if (instr_data_valid_op) bad++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (!instr_mem_req_op) begin
      failures++;
      $display("FAIL fetch_req_timeout req=%b required=1", instr_mem_req_op);
    end
    addr = instr_mem_addr_op;
    for (int i = 0; i <= gd; i++) begin
      if (instr_mem_req_op && instr_mem_addr_op === addr) held++;
      if (instr_data_valid_op) bad++;
      instr_mem_gnt_ip = i == gd;
      instr_mem_rvalid_ip = noise && $urandom_range(1) == 1;
      instr_mem_rdata_ip = $urandom;
      retire_ip = noise && $urandom_range(1) == 1;
      pc_mux_ip = $urandom_range(1) == 1 ? OFFSET : NEXTPC;
      pc_branch_offset_ip = $urandom;
      if (i < gd) @(negedge clk);
    end
    @(negedge clk);
    instr_mem_gnt_ip = 0;
    for (int i = 0; i <= rd; i++) begin
      if (instr_data_valid_op || instr_mem_req_op) bad++;
      instr_mem_rvalid_ip = i == rd;
      instr_mem_rdata_ip = i == rd ? data : $urandom;
      retire_ip = noise && $urandom_range(1) == 1;
      @(negedge clk);
    end
    instr_mem_rvalid_ip = 0;
    retire_ip = 0;
  endtask

  task automatic retire(input pc_mux m, input logic [31:0] off);
    pc_mux_ip = m;
    pc_branch_offset_ip = off;
    retire_ip = 1;
    @(negedge clk);
    retire_ip = 0;
    model_retire(m, off);
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    #1;
    checks += 6;
    if (pc_op !== RP) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc_op, RP); end
    if (instr_mem_req_op !== 0) begin failures++; $display("FAIL reset_req got=%b exp=0", instr_mem_req_op); end
    if (instr_data_valid_op !== 0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_data_valid_op); end
    if (instr_data_op !== 0) begin failures++; $display("FAIL reset_data got=%h exp=0", instr_data_op); end
    if (fetch_error_op !== 0) begin failures++; $display("FAIL reset_err got=%b exp=0", fetch_error_op); end
    if (retired_count_op !== 0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", retired_count_op); end
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_first_fetch();
    logic [31:0] a;
    int h, b;
    checks += 2;
    if (instr_mem_req_op !== 0) begin failures++; $display("FAIL first_idle_req got=%b exp=0", instr_mem_req_op); end
    @(negedge clk);
    if (instr_mem_req_op !== 1 || instr_mem_addr_op !== RP)
      begin failures++; $display("FAIL first_cycle1_req got=%b/%h exp=1/%h", instr_mem_req_op, instr_mem_addr_op, RP); end
    fetch(0, 0, 32'h0000_0013, 0, a, h, b);
    checks += 4;
    if (b !== 0) begin failures++; $display("FAIL first_early_valid got=%0d exp=0", b); end
    if (instr_data_valid_op !== 1) begin failures++; $display("FAIL first_valid_cycle3 got=%b exp=1", instr_data_valid_op); end
    if (instr_data_op !== 32'h13) begin failures++; $display("FAIL first_data got=%h exp=00000013", instr_data_op); end
    if (pc4_op !== exp_pc + 4) begin failures++; $display("FAIL first_pc4 got=%h exp=%h", pc4_op, exp_pc + 4); end
    retire(NEXTPC, 0);
    checks += 2;
    if (pc_op !== exp_pc) begin failures++; $display("FAIL first_retire_pc got=%h exp=%h", pc_op, exp_pc); end
    if (retired_count_op !== exp_cnt) begin failures++; $display("FAIL first_retire_cnt got=%h exp=%h", retired_count_op, exp_cnt); end
  endtask

  task automatic test_gnt_stall();
    logic [31:0] a, d = $urandom;
    int h, b;
    fetch(3, 0, d, 0, a, h, b);
    checks += 5;
    if (a !== exp_pc) begin failures++; $display("FAIL stall_addr got=%h exp=%h", a, exp_pc); end
    if (h !== 4) begin failures++; $display("FAIL stall_req_held got=%0d exp=4", h); end
    if (b !== 0) begin failures++; $display("FAIL stall_early_valid got=%0d exp=0", b); end
    if (instr_data_valid_op !== 1) begin failures++; $display("FAIL stall_valid got=%b exp=1", instr_data_valid_op); end
    if (instr_data_op !== d) begin failures++; $display("FAIL stall_data got=%h exp=%h", instr_data_op, d); end
    retire(OFFSET, 32'h100 - exp_pc);
  endtask

  task automatic test_branch_back();
    logic [31:0] a;
    int h, b;
    fetch(0, 0, $urandom, 0, a, h, b);
    checks++;
    if (pc_op !== 32'h100) begin failures++; $display("FAIL branch_start_pc got=%h exp=00000100", pc_op); end
    retire(OFFSET, 32'hFFFF_FFF0);
    fetch(0, 0, $urandom, 0, a, h, b);
    checks += 2;
    if (a !== 32'h0F0) begin failures++; $display("FAIL branch_back_addr got=%h exp=000000f0", a); end
    if (retired_count_op !== exp_cnt) begin failures++; $display("FAIL branch_cnt got=%h exp=%h", retired_count_op, exp_cnt); end
    retire(OFFSET, 32'hFFFF_FFFC - exp_pc);
  endtask

  task automatic test_pc_wrap();
    logic [31:0] a;
    int h, b;
    fetch(0, 0, $urandom, 0, a, h, b);
    checks += 2;
    if (a !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr got=%h exp=fffffffc", a); end
    if (pc4_op !== 32'h0) begin failures++; $display("FAIL wrap_pc4 got=%h exp=00000000", pc4_op); end
    retire(NEXTPC, $urandom);
    fetch(0, 0, $urandom, 0, a, h, b);
    checks++;
    if (a !== 32'h0) begin failures++; $display("FAIL wrap_next_addr got=%h exp=00000000", a); end
    retire(NEXTPC, 0);
  endtask

  task automatic test_random();
    logic [31:0] a, d, off;
    int h, b, gd, rd;
    pc_mux m;
    for (int k = 0; k < 30; k++) begin
      gd = $urandom_range(3);
      rd = $urandom_range(3);
      d = $urandom;
      fetch(gd, rd, d, 1, a, h, b);
      checks += 5;
      if (a !== exp_pc) begin failures++; $display("FAIL rand_addr[%0d] got=%h exp=%h", k, a, exp_pc); end
      if (h !== gd + 1) begin failures++; $display("FAIL rand_req_held[%0d] got=%0d exp=%0d", k, h, gd + 1); end
      if (b !== 0) begin failures++; $display("FAIL rand_early[%0d] got=%0d exp=0", k, b); end
      if (instr_data_valid_op !== 1) begin failures++; $display("FAIL rand_valid[%0d] got=%b exp=1", k, instr_data_valid_op); end
      if (instr_data_op !== d) begin failures++; $display("FAIL rand_data[%0d] got=%h exp=%h", k, instr_data_op, d); end
      repeat ($urandom_range(2)) @(negedge clk);
      m = $urandom_range(1) == 1 ? OFFSET : NEXTPC;
      off = 32'($urandom) & 32'hFFFF_FFFC;
      retire(m, off);
      checks += 3;
      if (pc_op !== exp_pc) begin failures++; $display("FAIL rand_pc[%0d] got=%h exp=%h", k, pc_op, exp_pc); end
      if (retired_count_op !== exp_cnt) begin failures++; $display("FAIL rand_cnt[%0d] got=%h exp=%h", k, retired_count_op, exp_cnt); end
      if (fetch_error_op !== 0) begin failures++; $display("FAIL rand_err[%0d] got=%b exp=0", k, fetch_error_op); end
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] a, d = $urandom;
    int h, b, n = 0;
    while (!instr_mem_req_op && n < 10) begin @(negedge clk); n++; end
    instr_mem_gnt_ip = 1;
    @(negedge clk);
    instr_mem_gnt_ip = 0;
    checks++;
    if (instr_mem_req_op !== 0) begin failures++; $display("FAIL rw_wait_req got=%b exp=0", instr_mem_req_op); end
    rst_n = 0;
    instr_mem_rvalid_ip = 1;
    instr_mem_rdata_ip = 32'hDEAD_BEEF;
    #1;
    checks += 5;
    if (pc_op !== RP) begin failures++; $display("FAIL rw_pc got=%h exp=%h", pc_op, RP); end
    if (instr_mem_req_op !== 0 || instr_data_valid_op !== 0)
      begin failures++; $display("FAIL rw_req_valid got=%b/%b exp=0/0", instr_mem_req_op, instr_data_valid_op); end
    if (instr_data_op !== 0) begin failures++; $display("FAIL rw_data got=%h exp=0", instr_data_op); end
    if (retired_count_op !== 0) begin failures++; $display("FAIL rw_cnt got=%h exp=0", retired_count_op); end
    if (fetch_error_op !== 0) begin failures++; $display("FAIL rw_err got=%b exp=0", fetch_error_op); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_reset();
    @(negedge clk);
    checks += 2;
    if (instr_data_valid_op !== 0) begin failures++; $display("FAIL rw_late_valid got=%b exp=0", instr_data_valid_op); end
    if (instr_data_op !== 0) begin failures++; $display("FAIL rw_late_data got=%h exp=0", instr_data_op); end
    fetch(1, 1, d, 1, a, h, b);
    checks += 3;
    if (a !== RP) begin failures++; $display("FAIL rw_refetch_addr got=%h exp=%h", a, RP); end
    if (instr_data_op !== d) begin failures++; $display("FAIL rw_refetch_data got=%h exp=%h", instr_data_op, d); end
    if (b !== 0) begin failures++; $display("FAIL rw_refetch_early got=%0d exp=0", b); end
    retire(NEXTPC, 0);
  endtask

  task automatic test_halt();
    logic [31:0] a, hold_pc;
    int h, b, reqs = 0, vals = 0;
    fetch(0, 0, $urandom, 0, a, h, b);
    hold_pc = exp_pc;
    retire(OFFSET, 32'h6);
    checks += 4;
    if (!halted) begin failures++; $display("FAIL halt_model got=%b exp=1", halted); end
    if (fetch_error_op !== 1) begin failures++; $display("FAIL halt_err got=%b exp=1", fetch_error_op); end
    if (pc_op !== hold_pc) begin failures++; $display("FAIL halt_pc got=%h exp=%h", pc_op, hold_pc); end
    if (retired_count_op !== exp_cnt) begin failures++; $display("FAIL halt_cnt got=%h exp=%h", retired_count_op, exp_cnt); end
    for (int i = 0; i < 8; i++) begin
      if (instr_mem_req_op) reqs++;
      if (instr_data_valid_op) vals++;
      instr_mem_gnt_ip = 1;
      instr_mem_rvalid_ip = 1;
      retire_ip = 1;
      pc_mux_ip = NEXTPC;
      @(negedge clk);
    end
    instr_mem_gnt_ip = 0;
    instr_mem_rvalid_ip = 0;
    retire_ip = 0;
    checks += 4;
    if (reqs !== 0) begin failures++; $display("FAIL halt_reqs got=%0d exp=0", reqs); end
    if (vals !== 0) begin failures++; $display("FAIL halt_valid got=%0d exp=0", vals); end
    if (retired_count_op !== exp_cnt) begin failures++; $display("FAIL halt_cnt_frozen got=%h exp=%h", retired_count_op, exp_cnt); end
    if (pc_op !== hold_pc || fetch_error_op !== 1)
      begin failures++; $display("FAIL halt_sticky got=%h/%b exp=%h/1", pc_op, fetch_error_op, hold_pc); end
    apply_reset();
    fetch(0, 0, 32'h0000_0013, 0, a, h, b);
    checks += 2;
    if (a !== RP) begin failures++; $display("FAIL halt_recover_addr got=%h exp=%h", a, RP); end
    if (fetch_error_op !== 0) begin failures++; $display("FAIL halt_recover_err got=%b exp=0", fetch_error_op); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_gnt_stall();
    test_branch_back();
    test_pc_wrap();
    test_random();
    test_reset_in_wait();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
